// File: rtl/i2s_codec_port_if.sv
// -----------------------------------------------------------------------------
// i2s_codec_port_if
// Sample-side bus between the audio datapath and the codec serial port.
//   tx_l, tx_r   DAC sample pair offered by the datapath
//   tx_valid     tx pair valid
//   tx_ready     port holding buffer is empty
//   rx_l, rx_r   last complete ADC pair
//   rx_valid     one-cycle pulse when rx_l/rx_r update
// master = datapath side, slave = codec port side.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
interface i2s_codec_port_if #(
    parameter int SAMPLE_W = 16
);
    logic [SAMPLE_W-1:0] tx_l;
    logic [SAMPLE_W-1:0] tx_r;
    logic                tx_valid;
    logic                tx_ready;
    logic [SAMPLE_W-1:0] rx_l;
    logic [SAMPLE_W-1:0] rx_r;
    logic                rx_valid;

    modport master (
        output tx_l, tx_r, tx_valid,
        input  tx_ready, rx_l, rx_r, rx_valid
    );

    modport slave (
        input  tx_l, tx_r, tx_valid,
        output tx_ready, rx_l, rx_r, rx_valid
    );
endinterface

// File: rtl/i2s_codec_port.sv
// -----------------------------------------------------------------------------
// i2s_codec_port
// Master-mode serial port to a WM8731-class audio codec. Derives BCLK and LRCK
// from clk, serialises a stereo DAC frame from a 1-entry holding buffer and
// deserialises a stereo ADC frame. Supports I2S (data delayed one BCLK after
// the LRCK edge) and left-justified framing.
//
// Ports
//   clk, reset         system clock, synchronous active-high reset
//   bus (slave)        tx_l/tx_r/tx_valid/tx_ready, rx_l/rx_r/rx_valid
//   i2s_mode           1 = I2S, 0 = left-justified; sampled at frame boundary
//   mute               forces AUD_DACDAT low; buffer still consumed
//   underrun           sticky; a frame started with the buffer empty
//   AUD_BCLK           bit clock
//   AUD_DACLRCK        DAC word clock (0 = left slot)
//   AUD_ADCLRCK        ADC word clock, identical to AUD_DACLRCK
//   AUD_DACDAT         serial DAC data, changes on BCLK falling edges
//   AUD_ADCDAT         serial ADC data, sampled on BCLK rising edges
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module i2s_codec_port #(
    parameter int SAMPLE_W  = 16,
    parameter int BCLK_DIV  = 4,
    parameter int SLOT_BITS = 32
) (
    input  logic               clk,
    input  logic               reset,
    i2s_codec_port_if.slave    bus,
    input  logic               i2s_mode,
    input  logic               mute,
    output logic               underrun,
    output logic               AUD_BCLK,
    output logic               AUD_DACLRCK,
    output logic               AUD_ADCLRCK,
    output logic               AUD_DACDAT,
    input  logic               AUD_ADCDAT
);

    localparam int DW = $clog2(BCLK_DIV);
    localparam int BW = $clog2(2 * SLOT_BITS);

    localparam logic [DW-1:0] DIV_LAST = DW'(BCLK_DIV - 1);
    localparam logic [DW-1:0] DIV_HALF = DW'(BCLK_DIV / 2);
    localparam logic [BW-1:0] BIT_LAST = BW'(2 * SLOT_BITS - 1);
    localparam logic [BW-1:0] R_FIRST  = BW'(SLOT_BITS);

    // Data index within a slot: negative before the MSB (I2S delay bit),
    // >= SAMPLE_W in the padding after the LSB.
    function automatic int data_idx(input logic [BW-1:0] bc, input logic dly);
        int pos;
        pos = int'(bc);
        if (pos >= SLOT_BITS) pos = pos - SLOT_BITS;
        return pos - int'(dly);
    endfunction

    function automatic logic tx_bit(input logic [SAMPLE_W-1:0] s, input int d);
        logic b;
        b = 1'b0;
        if (d >= 0 && d < SAMPLE_W) b = s[SAMPLE_W-1-d];
        return b;
    endfunction

    logic [DW-1:0]       div_cnt_q, div_cnt_d;
    logic [BW-1:0]       bit_cnt_q, bit_cnt_d;
    logic                dly_q, dly_d;
    logic                bclk_q, lrck_q, dacdat_q, dacdat_d;
    logic                full_q, full_d;
    logic                underrun_q, underrun_d;
    logic [SAMPLE_W-1:0] buf_l_q, buf_l_d, buf_r_q, buf_r_d;
    logic [SAMPLE_W-1:0] tx_frame_l_q, tx_frame_l_d, tx_frame_r_q, tx_frame_r_d;
    logic [SAMPLE_W-1:0] sh_l_q, sh_l_d, sh_r_q, sh_r_d;
    logic                rx_done_q, rx_done_d;
    logic [SAMPLE_W-1:0] rx_l_q, rx_l_d, rx_r_q, rx_r_d;
    logic                rx_valid_q, rx_valid_d;

    logic div_wrap, frame_wrap, rise_ev, take, rx_cap;
    int   tx_idx, rx_idx;

    always_comb begin
        div_wrap   = (div_cnt_q == DIV_LAST);
        div_cnt_d  = div_wrap ? '0 : div_cnt_q + DW'(1);
        frame_wrap = div_wrap && (bit_cnt_q == BIT_LAST);
        bit_cnt_d  = bit_cnt_q;
        if (div_wrap) bit_cnt_d = frame_wrap ? '0 : bit_cnt_q + BW'(1);
        rise_ev    = (div_cnt_d == DIV_HALF);
        dly_d      = frame_wrap ? i2s_mode : dly_q;

        // Holding buffer. Capture is only possible while empty, so a capture
        // coinciding with a boundary always follows the unload of the old pair.
        take         = bus.tx_valid && !full_q;
        full_d       = full_q;
        underrun_d   = underrun_q;
        buf_l_d      = buf_l_q;
        buf_r_d      = buf_r_q;
        tx_frame_l_d = tx_frame_l_q;
        tx_frame_r_d = tx_frame_r_q;
        if (frame_wrap) begin
            if (full_q) begin
                tx_frame_l_d = buf_l_q;
                tx_frame_r_d = buf_r_q;
                full_d       = 1'b0;
            end else begin
                underrun_d = 1'b1;
            end
        end
        if (take) begin
            buf_l_d = bus.tx_l;
            buf_r_d = bus.tx_r;
            full_d  = 1'b1;
        end

        // DAC bit is chosen from next-state counters so it is on the pin
        // in the same cycle BCLK falls (MSB at the boundary for LJ).
        tx_idx   = data_idx(bit_cnt_d, dly_d);
        dacdat_d = dacdat_q;
        if (div_wrap)
            dacdat_d = mute ? 1'b0
                            : tx_bit((bit_cnt_d >= R_FIRST) ? tx_frame_r_d : tx_frame_l_d, tx_idx);

        // ADC capture on the rising BCLK edge
        rx_idx = data_idx(bit_cnt_q, dly_q);
        rx_cap = rise_ev && (rx_idx >= 0) && (rx_idx < SAMPLE_W);
        sh_l_d = sh_l_q;
        sh_r_d = sh_r_q;
        if (rx_cap) begin
            if (lrck_q) sh_r_d = {sh_r_q[SAMPLE_W-2:0], AUD_ADCDAT};
            else        sh_l_d = {sh_l_q[SAMPLE_W-2:0], AUD_ADCDAT};
        end
        rx_done_d  = rx_cap && lrck_q && (rx_idx == SAMPLE_W - 1);
        rx_valid_d = rx_done_q;
        rx_l_d     = rx_done_q ? sh_l_q : rx_l_q;
        rx_r_d     = rx_done_q ? sh_r_q : rx_r_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt_q    <= '0;
            bit_cnt_q    <= '0;
            dly_q        <= 1'b0;
            bclk_q       <= 1'b0;
            lrck_q       <= 1'b0;
            dacdat_q     <= 1'b0;
            full_q       <= 1'b0;
            underrun_q   <= 1'b0;
            tx_frame_l_q <= '0;
            tx_frame_r_q <= '0;
            sh_l_q       <= '0;
            sh_r_q       <= '0;
            rx_done_q    <= 1'b0;
            rx_l_q       <= '0;
            rx_r_q       <= '0;
            rx_valid_q   <= 1'b0;
        end else begin
            div_cnt_q    <= div_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            dly_q        <= dly_d;
            bclk_q       <= (div_cnt_d >= DIV_HALF);
            lrck_q       <= (bit_cnt_d >= R_FIRST);
            dacdat_q     <= dacdat_d;
            full_q       <= full_d;
            underrun_q   <= underrun_d;
            tx_frame_l_q <= tx_frame_l_d;
            tx_frame_r_q <= tx_frame_r_d;
            sh_l_q       <= sh_l_d;
            sh_r_q       <= sh_r_d;
            rx_done_q    <= rx_done_d;
            rx_l_q       <= rx_l_d;
            rx_r_q       <= rx_r_d;
            rx_valid_q   <= rx_valid_d;
        end
    end

    // Buffer contents are qualified by full_q and need no reset
    always_ff @(posedge clk) begin
        buf_l_q <= buf_l_d;
        buf_r_q <= buf_r_d;
    end

    assign bus.tx_ready = !full_q;
    assign bus.rx_l     = rx_l_q;
    assign bus.rx_r     = rx_r_q;
    assign bus.rx_valid = rx_valid_q;
    assign underrun     = underrun_q;
    assign AUD_BCLK     = bclk_q;
    assign AUD_DACLRCK  = lrck_q;
    assign AUD_ADCLRCK  = lrck_q;
    assign AUD_DACDAT   = dacdat_q;

endmodule
